fpu_result_retire: RTL and testbench

- Downstream retire stage for the FP16 add/sub datapath.
- Registers each result packet (fp16 value, condition codes, status flags) into a 2-entry elastic buffer with valid/ready on both sides.
- Optionally canonicalises NaNs, and maintains the architectural sticky status-flag register, last-retired condition codes and a retire counter.
- Cuts the combinational path between the arithmetic unit and the register-file writeback.

---
 rtl/fpu_result_retire_pkg.sv | 44 ++++
 rtl/fpu_result_fifo.sv | 94 +++++++++
 rtl/fpu_result_retire.sv | 98 +++++++++
 tb/tb_fpu_result_retire.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_result_retire_pkg.sv
// Shared FP16 retire-stage types: fp16 value, condition codes, per-op status
// flags, the packet carried through the retire buffer, and a NaN test helper.
package fpu_result_retire_pkg;

    localparam int unsigned FP16_EXPW  = 5;
    localparam int unsigned FP16_FRACW = 10;
    localparam int unsigned FP16_W     = 1 + FP16_EXPW + FP16_FRACW;

    // Quiet NaN with only the top fraction bit set.
    localparam logic [FP16_W-1:0] FP16_CANON_NAN = 16'h7E00;

    typedef struct packed {
        logic                  sign;
        logic [FP16_EXPW-1:0]  exp;
        logic [FP16_FRACW-1:0] frac;
    } fp16_t;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } condCode_t;

    typedef struct packed {
        logic invalid;
        logic div_zero;
        logic overflow;
        logic underflow;
        logic inexact;
    } opStatusFlag_t;

    typedef struct packed {
        fp16_t         result;
        condCode_t     cond_codes;
        opStatusFlag_t flags;
    } fpuResultPkt_t;

    // All-ones exponent with a non-zero fraction; infinities are excluded.
    function automatic logic is_nan(input fp16_t value);
        return (value.exp == '1) && (value.frac != '0);
    endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// Two-entry elastic buffer for result packets.
// Ports:
//   clock, reset            : clock and synchronous active-high reset
//   push_valid/push_ready   : upstream handshake (push_ready registered)
//   push_pkt                : incoming packet
//   pop_valid/pop_ready     : downstream handshake (pop_valid registered)
//   pop_pkt                 : head packet, all-zero when empty
module fpu_result_fifo
    import fpu_result_retire_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_valid,
    output logic          push_ready,
    input  fpuResultPkt_t push_pkt,
    output logic          pop_valid,
    input  logic          pop_ready,
    output fpuResultPkt_t pop_pkt
);

    localparam int unsigned CNT_W = 2;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    fpuResultPkt_t    head_q;
    fpuResultPkt_t    head_d;
    fpuResultPkt_t    tail_q;
    fpuResultPkt_t    tail_d;
    logic             ready_q;
    logic             valid_q;
    logic             push;
    logic             pop;

    assign push = push_valid && ready_q;
    assign pop  = valid_q && pop_ready;

    // Head always holds the oldest entry; tail only holds the second one.
    // Vacated slots are zeroed so an empty buffer presents no stale data.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (count_q)
            CNT_W'(0): begin
                if (push) begin
                    head_d  = push_pkt;
                    count_d = CNT_W'(1);
                end
            end
            CNT_W'(1): begin
                if (push && pop) begin
                    head_d = push_pkt;
                end else if (push) begin
                    tail_d  = push_pkt;
                    count_d = CNT_W'(2);
                end else if (pop) begin
                    head_d  = '0;
                    count_d = CNT_W'(0);
                end
            end
            default: begin
                if (pop) begin
                    head_d  = tail_q;
                    tail_d  = '0;
                    count_d = CNT_W'(1);
                end
            end
        endcase
    end

    // Storage plus registered handshake flags derived from next occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= (count_d != CNT_W'(DEPTH));
            valid_q <= (count_d != CNT_W'(0));
        end
    end

    assign push_ready = ready_q;
    assign pop_valid  = valid_q;
    assign pop_pkt    = head_q;

endmodule

// File: rtl/fpu_result_retire.sv
// Retire stage for the FP16 add/sub datapath: buffers results, optionally
// canonicalises NaNs, and keeps sticky flags, last condition codes and a
// retire counter.
// Ports:
//   clock, reset                   : clock and synchronous active-high reset
//   inValid/inReady                : upstream handshake
//   inResult/inCondCodes/inFlags   : incoming result packet
//   outValid/outReady              : writeback handshake
//   outResult/outCondCodes/outFlags: head packet (NaN canonicalised)
//   stickyFlags                    : OR of retired flags since clear/reset
//   lastCondCodes                  : codes of most recently retired op
//   clearSticky                    : clear stickyFlags
//   retireCount                    : retired-op counter, wraps
module fpu_result_retire
    import fpu_result_retire_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter bit          CANON_NAN = 1'b1,
    parameter int unsigned CNTW      = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            inValid,
    output logic            inReady,
    input  fp16_t           inResult,
    input  condCode_t       inCondCodes,
    input  opStatusFlag_t   inFlags,
    output logic            outValid,
    input  logic            outReady,
    output fp16_t           outResult,
    output condCode_t       outCondCodes,
    output opStatusFlag_t   outFlags,
    output opStatusFlag_t   stickyFlags,
    output condCode_t       lastCondCodes,
    input  logic            clearSticky,
    output logic [CNTW-1:0] retireCount
);

    fpuResultPkt_t in_pkt;
    fpuResultPkt_t head_pkt;
    logic          retire;
    opStatusFlag_t sticky_q;
    condCode_t     last_cc_q;
    logic [CNTW-1:0] count_q;

    always_comb begin
        in_pkt            = '0;
        in_pkt.result     = inResult;
        in_pkt.cond_codes = inCondCodes;
        in_pkt.flags      = inFlags;
    end

    fpu_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_valid (inValid),
        .push_ready (inReady),
        .push_pkt   (in_pkt),
        .pop_valid  (outValid),
        .pop_ready  (outReady),
        .pop_pkt    (head_pkt)
    );

    assign retire = outValid && outReady;

    // Canonicalisation sits on the output mux; the stored packet is untouched.
    assign outResult    = (CANON_NAN && is_nan(head_pkt.result))
                          ? fp16_t'(FP16_CANON_NAN) : head_pkt.result;
    assign outCondCodes = head_pkt.cond_codes;
    assign outFlags     = head_pkt.flags;

    // Architectural state; a same-cycle clear happens before the retiring
    // op's flags are merged, so those flags survive the clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            sticky_q  <= '0;
            last_cc_q <= '0;
            count_q   <= '0;
        end else begin
            if (clearSticky) begin
                sticky_q <= retire ? head_pkt.flags : opStatusFlag_t'('0);
            end else if (retire) begin
                sticky_q <= sticky_q | head_pkt.flags;
            end
            if (retire) begin
                last_cc_q <= head_pkt.cond_codes;
                count_q   <= count_q + CNTW'(1);
            end
        end
    end

    assign stickyFlags   = sticky_q;
    assign lastCondCodes = last_cc_q;
    assign retireCount   = count_q;

endmodule

// File: tb/tb_fpu_result_retire.sv
// Self-checking bench for fpu_result_retire (CNTW=4, CANON_NAN=1).
module tb_fpu_result_retire;

    logic        clock = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [15:0] inResult;
    logic [3:0]  inCondCodes;
    logic [4:0]  inFlags;
    logic        outValid;
    logic        outReady;
    logic [15:0] outResult;
    logic [3:0]  outCondCodes;
    logic [4:0]  outFlags;
    logic [4:0]  stickyFlags;
    logic [3:0]  lastCondCodes;
    logic        clearSticky;
    logic [3:0]  retireCount;

    always #5 clock = ~clock;

    fpu_result_retire #(
        .DEPTH     (2),
        .CANON_NAN (1'b1),
        .CNTW      (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .inValid       (inValid),
        .inReady       (inReady),
        .inResult      (inResult),
        .inCondCodes   (inCondCodes),
        .inFlags       (inFlags),
        .outValid      (outValid),
        .outReady      (outReady),
        .outResult     (outResult),
        .outCondCodes  (outCondCodes),
        .outFlags      (outFlags),
        .stickyFlags   (stickyFlags),
        .lastCondCodes (lastCondCodes),
        .clearSticky   (clearSticky),
        .retireCount   (retireCount)
    );

    // Reference model: a plain queue of packets plus architectural state.
    typedef struct {
        logic [15:0] r;
        logic [3:0]  cc;
        logic [4:0]  fl;
    } pkt_t;

    pkt_t       q[$];
    logic [4:0] m_sticky;
    logic [3:0] m_last;
    int         m_count;
    bit         last_acc;
    int         checks = 0;
    int         errors = 0;

    function automatic logic [15:0] canon(input logic [15:0] v);
        if ((((v >> 10) & 16'h1F) == 16'h1F) && ((v & 16'h3FF) != 16'h0))
            return 16'h7E00;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [15:0] e_res;
        logic [3:0]  e_cc;
        logic [4:0]  e_fl;
        e_res = 16'h0; e_cc = 4'h0; e_fl = 5'h0;
        if (q.size() > 0) begin
            e_res = canon(q[0].r);
            e_cc  = q[0].cc;
            e_fl  = q[0].fl;
        end
        chk("outValid",      32'(outValid),      32'(q.size() > 0));
        chk("inReady",       32'(inReady),       32'(q.size() < 2));
        chk("outResult",     32'(outResult),     32'(e_res));
        chk("outCondCodes",  32'(outCondCodes),  32'(e_cc));
        chk("outFlags",      32'(outFlags),      32'(e_fl));
        chk("stickyFlags",   32'(stickyFlags),   32'(m_sticky));
        chk("lastCondCodes", 32'(lastCondCodes), 32'(m_last));
        chk("retireCount",   32'(retireCount),   32'(m_count));
    endtask

    // One clock: apply current inputs, advance the model, check at negedge.
    task automatic step();
        bit   acc;
        bit   ret;
        pkt_t p;
        acc = inValid && (q.size() < 2);
        ret = outReady && (q.size() > 0);
        @(posedge clock);
        if (reset) begin
            q.delete();
            m_sticky = 5'h0;
            m_last   = 4'h0;
            m_count  = 0;
            last_acc = 1'b0;
        end else begin
            if (ret) begin
                p        = q.pop_front();
                m_sticky = (clearSticky ? 5'h0 : m_sticky) | p.fl;
                m_last   = p.cc;
                m_count  = (m_count + 1) % 16;
            end else if (clearSticky) begin
                m_sticky = 5'h0;
            end
            if (acc) begin
                p.r  = inResult;
                p.cc = inCondCodes;
                p.fl = inFlags;
                q.push_back(p);
            end
            last_acc = acc;
        end
        @(negedge clock);
        check_all();
    endtask

    task automatic drive(input logic v, input logic [15:0] r, input logic [3:0] cc, input logic [4:0] fl);
        inValid     = v;
        inResult    = r;
        inCondCodes = cc;
        inFlags     = fl;
    endtask

    function automatic logic [15:0] rand_result();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 3))
            0: v = {v[15], 5'h1F, v[9:0]};
            1: v = {v[15], 5'h1F, 10'h0};
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        reset = 1'b1; outReady = 1'b0; clearSticky = 1'b0;
        drive(1'b0, 16'h0, 4'h0, 5'h0);
        m_sticky = 5'h0; m_last = 4'h0; m_count = 0; last_acc = 1'b0;
        step(); step();
        reset = 1'b0;
        step();

        // Reset in the middle of a full buffer.
        drive(1'b1, 16'h3C00, 4'h1, 5'h01); step();
        drive(1'b1, 16'h4000, 4'h2, 5'h02); step();
        chk("full_inReady", 32'(inReady), 32'd0);
        drive(1'b0, 16'h0, 4'h0, 5'h0);
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst_outValid", 32'(outValid), 32'd0);
        chk("rst_inReady",  32'(inReady),  32'd1);
        chk("rst_sticky",   32'(stickyFlags), 32'd0);
        chk("rst_count",    32'(retireCount), 32'd0);
        outReady = 1'b1; step(); step();

        // Streaming at full rate.
        drive(1'b1, 16'h3C00, 4'h1, 5'h00); step();
        chk("stream_h0", 32'(outResult), 32'h3C00);
        drive(1'b1, 16'h4000, 4'h2, 5'h00); step();
        chk("stream_h1", 32'(outResult), 32'h4000);
        drive(1'b1, 16'h4200, 4'h3, 5'h00); step();
        chk("stream_h2", 32'(outResult), 32'h4200);
        drive(1'b0, 16'h0, 4'h0, 5'h0); step();
        chk("stream_count", 32'(retireCount), 32'd3);

        // Backpressure: third packet held while full, head stable.
        outReady = 1'b0;
        drive(1'b1, 16'h3C00, 4'h4, 5'h00); step();
        drive(1'b1, 16'h4000, 4'h5, 5'h00); step();
        chk("bp_full", 32'(inReady), 32'd0);
        drive(1'b1, 16'h4200, 4'h6, 5'h00);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_head", 32'(outResult), 32'h3C00);
        end
        outReady = 1'b1; step();
        chk("bp_d0", 32'(outResult), 32'h4000);
        step();
        chk("bp_d1", 32'(outResult), 32'h4200);
        drive(1'b0, 16'h0, 4'h0, 5'h0); step();
        chk("bp_count", 32'(retireCount), 32'd6);

        // NaN canonicalisation; infinity passes.
        outReady = 1'b0;
        drive(1'b1, 16'hFD55, 4'h7, 5'h10); step();
        chk("nan_canon", 32'(outResult), 32'h7E00);
        outReady = 1'b1;
        drive(1'b1, 16'h7C00, 4'h8, 5'h00); step();
        chk("inf_pass", 32'(outResult), 32'h7C00);
        drive(1'b0, 16'h0, 4'h0, 5'h0); step();

        // Sticky accumulation and clear-with-retire.
        clearSticky = 1'b1; step(); clearSticky = 1'b0;
        drive(1'b1, 16'h3C00, 4'h1, 5'b00100); step();
        drive(1'b1, 16'h3C00, 4'h2, 5'b00001); step();
        drive(1'b0, 16'h0, 4'h0, 5'h0); step();
        chk("sticky_or", 32'(stickyFlags), 32'b00101);
        outReady = 1'b0;
        drive(1'b1, 16'h3C00, 4'h3, 5'b10000); step();
        drive(1'b0, 16'h0, 4'h0, 5'h0);
        outReady = 1'b1; clearSticky = 1'b1; step(); clearSticky = 1'b0;
        chk("sticky_clr_ret", 32'(stickyFlags), 32'b10000);

        // Counter wrap after 17 retires.
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 16'(16'h3C00 + i), 4'(i), 5'h00);
            step();
        end
        drive(1'b0, 16'h0, 4'h0, 5'h0); step();
        chk("wrap_count", 32'(retireCount), 32'd1);

        // Simultaneous accept and retire with one entry held.
        outReady = 1'b0;
        drive(1'b1, 16'h4100, 4'hA, 5'h00); step();
        outReady = 1'b1;
        drive(1'b1, 16'h4400, 4'h5, 5'h00); step();
        chk("sim_valid", 32'(outValid),      32'd1);
        chk("sim_head",  32'(outResult),     32'h4400);
        chk("sim_last",  32'(lastCondCodes), 32'hA);
        chk("sim_ready", 32'(inReady),       32'd1);
        drive(1'b0, 16'h0, 4'h0, 5'h0); step();

        // Randomised traffic; an unaccepted packet is held until taken.
        for (int i = 0; i < 800; i++) begin
            if (!(inValid && !last_acc)) begin
                drive(($urandom_range(0, 3) != 0), rand_result(),
                      4'($urandom), 5'($urandom));
            end
            outReady    = ($urandom_range(0, 9) < 7);
            clearSticky = ($urandom_range(0, 9) == 0);
            reset       = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0; outReady = 1'b1; clearSticky = 1'b0;
        drive(1'b0, 16'h0, 4'h0, 5'h0);
        step(); step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
